mapper90_irq_ctrl: RTL
======================

MAPPER90_IRQ_CTRL -- requirements
Module: mapper90_irq_ctrl

Interface
REQ-001 SHALL have parameter A12_FILTER, default 3: the number of consecutive sampled-low m2 cycles of ppu_a12 required before a rise counts as an event.
REQ-002 SHALL have port m2, input, 1 bit: the CPU M2 clock and the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port wr_en, input, 1 bit: one-cycle strobe for a CPU write to $C000-$C007.
REQ-005 SHALL have port wr_addr, input, 3 bits: register offset (cpu_addr[2:0]).
REQ-006 SHALL have port wr_data, input, 8 bits: CPU write data.
REQ-007 SHALL have port ppu_a12, input, 1 bit: raw, asynchronous PPU A12.
REQ-008 SHALL have port ppu_rd_evt, input, 1 bit: externally synchronised one-cycle PPU-read event.
REQ-009 SHALL have port irq, output, 1 bit: active-low IRQ to the CPU, registered.
REQ-010 SHALL have port irq_en, output, 1 bit: current enable state.
REQ-011 SHALL have port irq_count, output, 8 bits: current counter value.
REQ-012 SHALL have port irq_prescale, output, 8 bits: current prescaler value.

Function
REQ-013 The register map SHALL be:
- offset 0: enable = wr_data[0]
- offset 1: mode = wr_data
- offset 2: enable = 0, and acknowledge (irq = 1)
- offset 3: enable = 1
- offset 4: prescaler load
- offset 5: counter load
- offset 6: xor = wr_data
- offset 7: ignored
REQ-014 Mode fields SHALL be:
- [1:0] event source: 00 every m2 cycle, 01 filtered A12 rise, 10 ppu_rd_evt, 11 any wr_en
- [2] prescaler width: 0 = 8-bit, 1 = 3-bit
- [7:6] direction: 01 up, 10 down, 00/11 halt (no counting)
REQ-015 The load value SHALL be wr_data ^ xor ^ (direction==up ? 8'hFF : 8'h00).
REQ-016 In 3-bit width, a prescaler load SHALL write only bits [2:0], and bits [7:3] SHALL hold.
REQ-017 Each event SHALL step the prescaler by one in the selected direction; only [2:0] steps in 3-bit width.
REQ-018 Prescaler wrap (up 0xFF/7->0, down 0->0xFF/7) SHALL step the counter once in the same direction.
REQ-019 Counter wrap (up 0xFF->0x00, down 0x00->0xFF) with enable=1 SHALL drive irq low at the same edge.
REQ-020 irq SHALL stay low until an offset-2 write or reset; an offset-0 write with data[0]=0 SHALL NOT clear it.
REQ-021 ppu_a12 SHALL pass through a 2-flop synchroniser; an event is a low-to-high transition after at least A12_FILTER consecutive low samples.
REQ-022 Counter/prescaler update latency from a raw A12 rise SHALL be 3 m2 edges; from ppu_rd_evt, wr_en or m2 mode, 1 edge.
REQ-023 Simultaneous prescaler or counter load and event: the load SHALL win and the event is dropped for that register.
REQ-024 Simultaneous offset-2 write and counter wrap: the acknowledge SHALL win (irq = 1, enable = 0).
REQ-025 Simultaneous offset-3 or offset-0 (data[0]=1) write and wrap: irq SHALL assert.
REQ-026 In mode source 11, the write strobe SHALL count as an event even when it writes a register; REQ-023 applies.
REQ-027 A mode write SHALL take effect for events from the next cycle; the A12 filter history SHALL be retained.

Reset
REQ-028 While rst_n=0 at a rising m2 edge, the following SHALL all be 0: mode, xor, prescaler, counter, enable, synchroniser and filter state.
REQ-029 While rst_n=0 at a rising m2 edge, irq SHALL be 1.
REQ-030 Reset asserted mid-count or with irq low SHALL discard all state with no pending IRQ.

Structure
REQ-031 Package mapper90_irq_pkg SHALL hold the register-offset constants, the source/direction/width encodings and the mode bit positions.
REQ-032 One sub-module, mapper90_a12_filter, SHALL contain the synchroniser, the low-run counter and the edge detector, outputting a one-cycle event.
REQ-033 The implementation SHALL be 120-400 lines of RTL, with no latches and no clocks other than m2.

Verification
REQ-034 Down-count in m2 mode:
- stimulus: mode=8'h80 (down, m2, 8-bit), xor=0, prescaler=0x02, counter=0x01, enable=1
- response: counter 0x00 after 3 cycles; irq low exactly 259 cycles after the last load.
REQ-035 Up-count with xor, 3-bit width, ppu_rd_evt source:
- stimulus: mode=8'h46, xor=8'h0F, counter load data 0xF0
- response: counter loads 0x00 (0xF0^0x0F^0xFF); 2048 events wrap it, irq low.
REQ-036 A12 filter:
- stimulus: A12 pulses high after only 2 low samples with A12_FILTER=3
- response: no count; after 3 low samples, a rise decrements the counter exactly 3 edges later.
REQ-037 Ack priority:
- stimulus: offset-2 write in the same cycle as the counter wrap
- response: irq stays 1, irq_en=0.
REQ-038 Load priority:
- stimulus: counter load 0x10 coincident with a prescaler wrap
- response: counter=0x10, not 0x0F.
REQ-039 Reset while irq is low and counting:
- stimulus: assert rst_n=0 for one edge
- response: irq=1; all outputs 0; no IRQ for 1000 m2 cycles with A12 toggling.

Source files
------------

// File: rtl/mapper90_irq_pkg.sv
// mapper90_irq_pkg
// Shared definitions for the mapper-90 scanline/cycle IRQ controller:
//   - register offsets within the $C000-$C007 window
//   - event-source, count-direction and prescaler-width encodings
//   - bit positions of the fields inside the mode register
//   - the load-value helper used by the prescaler and counter loads
package mapper90_irq_pkg;

  // Register offsets (cpu_addr[2:0])
  localparam logic [2:0] OFS_ENABLE = 3'd0;
  localparam logic [2:0] OFS_MODE   = 3'd1;
  localparam logic [2:0] OFS_ACK    = 3'd2;
  localparam logic [2:0] OFS_ARM    = 3'd3;
  localparam logic [2:0] OFS_PRE    = 3'd4;
  localparam logic [2:0] OFS_CNT    = 3'd5;
  localparam logic [2:0] OFS_XOR    = 3'd6;
  localparam logic [2:0] OFS_NONE   = 3'd7;

  // Mode register bit positions
  localparam int MODE_SRC_LSB   = 0;
  localparam int MODE_SRC_MSB   = 1;
  localparam int MODE_WIDTH_BIT = 2;
  localparam int MODE_DIR_LSB   = 6;
  localparam int MODE_DIR_MSB   = 7;

  typedef enum logic [1:0] {
    SRC_M2  = 2'b00,  // every m2 cycle
    SRC_A12 = 2'b01,  // filtered PPU A12 rise
    SRC_RD  = 2'b10,  // external PPU read event
    SRC_WR  = 2'b11   // any CPU write strobe
  } src_e;

  typedef enum logic [1:0] {
    DIR_HALT0 = 2'b00,
    DIR_UP    = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_HALT1 = 2'b11
  } dir_e;

  typedef enum logic {
    WIDTH_8 = 1'b0,
    WIDTH_3 = 1'b1
  } width_e;

  // Only the mode bits that influence behaviour are kept; bits [5:3] have
  // no function and are not stored.
  typedef struct packed {
    dir_e   dir;
    width_e width;
    src_e   src;
  } mode_t;

  function automatic mode_t decode_mode(input logic [7:0] data);
    mode_t m;
    m.dir   = dir_e'(data[MODE_DIR_MSB:MODE_DIR_LSB]);
    m.width = width_e'(data[MODE_WIDTH_BIT]);
    m.src   = src_e'(data[MODE_SRC_MSB:MODE_SRC_LSB]);
    return m;
  endfunction

  // Loads are XOR-scrambled, and additionally inverted when counting up so
  // that software writes "distance to wrap" in either direction.
  function automatic logic [7:0] load_value(input logic [7:0] data,
                                            input logic [7:0] xr,
                                            input logic       up);
    return data ^ xr ^ {8{up}};
  endfunction

endpackage

// File: rtl/mapper90_a12_filter.sv
// mapper90_a12_filter
// Turns the raw, asynchronous PPU A12 line into a one-cycle event on m2.
// A rise only counts after A12_FILTER consecutive low synchronised samples,
// which rejects the short A12 blips seen during background fetches.
//
// Ports
//   m2_i     : clock (CPU M2)
//   rst_n_i  : synchronous active-low reset
//   a12_i    : raw PPU A12
//   evt_o    : one-cycle filtered rise event (combinational from flops)
module mapper90_a12_filter #(
  parameter int A12_FILTER = 3
) (
  input  logic m2_i,
  input  logic rst_n_i,
  input  logic a12_i,
  output logic evt_o
);

  // A zero filter still needs one low sample to define a rise.
  localparam int LIMV = (A12_FILTER < 1) ? 1 : A12_FILTER;
  localparam int CW   = $clog2(LIMV + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMV);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] low_q, low_d;
  logic          a12_s;

  assign a12_s = sync_q[1];

  always_comb begin
    sync_d = {sync_q[0], a12_i};
    low_d  = low_q;
    // Run length of low samples, saturating at the filter limit.
    if (a12_s) begin
      low_d = '0;
    end else if (low_q != LIM) begin
      low_d = low_q + 1'b1;
    end
  end

  always_ff @(posedge m2_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      low_q  <= '0;
    end else begin
      sync_q <= sync_d;
      low_q  <= low_d;
    end
  end

  // low_q clears the cycle after A12 is seen high, so this is one cycle wide.
  assign evt_o = a12_s && (low_q >= LIM);

endmodule

// File: rtl/mapper90_irq_ctrl.sv
// mapper90_irq_ctrl
// Mapper-90 style IRQ block: a prescaler (8- or 3-bit) feeding an 8-bit
// counter, stepped up or down by a selectable event source. A counter wrap
// while enabled pulls the active-low IRQ, which stays low until acknowledged.
//
// Ports
//   m2           : CPU M2, the only clock
//   rst_n        : synchronous active-low reset
//   wr_en        : one-cycle CPU write strobe for $C000-$C007
//   wr_addr      : register offset
//   wr_data      : write data
//   ppu_a12      : raw PPU A12 (asynchronous)
//   ppu_rd_evt   : synchronised one-cycle PPU read event
//   irq          : active-low IRQ, registered
//   irq_en       : enable state
//   irq_count    : counter value
//   irq_prescale : prescaler value
module mapper90_irq_ctrl
  import mapper90_irq_pkg::*;
#(
  parameter int A12_FILTER = 3
) (
  input  logic       m2,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       ppu_a12,
  input  logic       ppu_rd_evt,
  output logic       irq,
  output logic       irq_en,
  output logic [7:0] irq_count,
  output logic [7:0] irq_prescale
);

  mode_t      mode_q, mode_d;
  logic [7:0] xor_q, xor_d;
  logic [7:0] pre_q, pre_d;
  logic [7:0] cnt_q, cnt_d;
  logic       en_q, en_d;
  logic       irq_q, irq_d;

  logic       a12_evt;
  logic       wr_enable, wr_mode, wr_ack, wr_arm, wr_pre, wr_cnt, wr_xor;
  logic       dir_up, dir_dn;
  logic       evt, step;
  logic [7:0] ld_val;
  logic [7:0] pre_inc, pre_dec, cnt_inc, cnt_dec;
  logic       pre_at_top, pre_at_zero;
  logic       pre_wrap, cnt_wrap;

  mapper90_a12_filter #(
    .A12_FILTER(A12_FILTER)
  ) u_a12_filter (
    .m2_i    (m2),
    .rst_n_i (rst_n),
    .a12_i   (ppu_a12),
    .evt_o   (a12_evt)
  );

  assign wr_enable = wr_en && (wr_addr == OFS_ENABLE);
  assign wr_mode   = wr_en && (wr_addr == OFS_MODE);
  assign wr_ack    = wr_en && (wr_addr == OFS_ACK);
  assign wr_arm    = wr_en && (wr_addr == OFS_ARM);
  assign wr_pre    = wr_en && (wr_addr == OFS_PRE);
  assign wr_cnt    = wr_en && (wr_addr == OFS_CNT);
  assign wr_xor    = wr_en && (wr_addr == OFS_XOR);

  assign dir_up = (mode_q.dir == DIR_UP);
  assign dir_dn = (mode_q.dir == DIR_DOWN);

  // Event source uses the registered mode, so a mode write only affects
  // events from the following cycle.
  always_comb begin
    evt = 1'b0;
    case (mode_q.src)
      SRC_M2:  evt = 1'b1;
      SRC_A12: evt = a12_evt;
      SRC_RD:  evt = ppu_rd_evt;
      SRC_WR:  evt = wr_en;
      default: evt = 1'b0;
    endcase
  end

  assign step   = evt && (dir_up || dir_dn);
  assign ld_val = load_value(wr_data, xor_q, dir_up);

  assign pre_inc = pre_q + 8'd1;
  assign pre_dec = pre_q - 8'd1;
  assign cnt_inc = cnt_q + 8'd1;
  assign cnt_dec = cnt_q - 8'd1;

  assign pre_at_top  = (mode_q.width == WIDTH_3) ? (pre_q[2:0] == 3'b111)
                                                 : (pre_q == 8'hFF);
  assign pre_at_zero = (mode_q.width == WIDTH_3) ? (pre_q[2:0] == 3'b000)
                                                 : (pre_q == 8'h00);

  // A load on the same cycle swallows the event for that register.
  assign pre_wrap = step && !wr_pre && (dir_up ? pre_at_top : pre_at_zero);
  assign cnt_wrap = pre_wrap && !wr_cnt &&
                    (dir_up ? (cnt_q == 8'hFF) : (cnt_q == 8'h00));

  always_comb begin
    pre_d = pre_q;
    if (wr_pre) begin
      if (mode_q.width == WIDTH_3) begin
        pre_d = {pre_q[7:3], ld_val[2:0]};
      end else begin
        pre_d = ld_val;
      end
    end else if (step) begin
      if (mode_q.width == WIDTH_3) begin
        pre_d = {pre_q[7:3], dir_up ? pre_inc[2:0] : pre_dec[2:0]};
      end else begin
        pre_d = dir_up ? pre_inc : pre_dec;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wr_cnt) begin
      cnt_d = ld_val;
    end else if (pre_wrap) begin
      cnt_d = dir_up ? cnt_inc : cnt_dec;
    end
  end

  always_comb begin
    mode_d = mode_q;
    xor_d  = xor_q;
    en_d   = en_q;
    if (wr_mode)   mode_d = decode_mode(wr_data);
    if (wr_xor)    xor_d  = wr_data;
    if (wr_enable) en_d   = wr_data[0];
    if (wr_ack)    en_d   = 1'b0;
    if (wr_arm)    en_d   = 1'b1;
  end

  // The enable written this cycle gates a coincident wrap, so arming and
  // wrapping together raises the IRQ; an acknowledge always wins.
  always_comb begin
    irq_d = irq_q;
    if (wr_ack) begin
      irq_d = 1'b1;
    end else if (cnt_wrap && en_d) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge m2) begin
    if (!rst_n) begin
      mode_q <= '0;
      xor_q  <= '0;
      pre_q  <= '0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      irq_q  <= 1'b1;
    end else begin
      mode_q <= mode_d;
      xor_q  <= xor_d;
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      irq_q  <= irq_d;
    end
  end

  assign irq          = irq_q;
  assign irq_en       = en_q;
  assign irq_count    = cnt_q;
  assign irq_prescale = pre_q;

endmodule
